// File: rtl/cam_power_sequencer_pkg.sv
// Shared types and defaults for the OV5642 power-up sequencer.
// Timing defaults assume the 100 MHz board clock.
package cam_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWDN  = 3'd1,
    S_RST   = 3'd2,
    S_WAIT  = 3'd3,
    S_READY = 3'd4
  } cam_state_e;

  localparam int unsigned T_PWDN_DEF = 100000;   // 1 ms
  localparam int unsigned T_RST_DEF  = 100000;   // 1 ms
  localparam int unsigned T_SCCB_DEF = 2000000;  // 20 ms

  typedef struct packed {
    logic pwdn;
    logic resetb;
    logic busy;
    logic ready;
  } cam_pins_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Moore decode of the sensor pins; PWDN is deasserted before RESETB is released.
  function automatic cam_pins_t pins_of(cam_state_e s);
    cam_pins_t p;
    p = '{pwdn: 1'b1, resetb: 1'b0, busy: 1'b0, ready: 1'b0};
    case (s)
      S_PWDN:  p.busy = 1'b1;
      S_RST:   begin p.pwdn = 1'b0; p.busy = 1'b1; end
      S_WAIT:  begin p.pwdn = 1'b0; p.resetb = 1'b1; p.busy = 1'b1; end
      S_READY: begin p.pwdn = 1'b0; p.resetb = 1'b1; p.ready = 1'b1; end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cam_power_sequencer_if.sv
// Control and sensor-pin bundle between reset conditioning, the sequencer and the SCCB master.
interface cam_power_sequencer_if;
  logic       i_restart;
  logic       i_pwr_down;
  logic       o_cam_pwdn;
  logic       o_cam_resetb;
  logic       o_busy;
  logic       o_ready;
  logic [2:0] o_state;

  modport master (
    output i_restart, i_pwr_down,
    input  o_cam_pwdn, o_cam_resetb, o_busy, o_ready, o_state
  );

  modport slave (
    input  i_restart, i_pwr_down,
    output o_cam_pwdn, o_cam_resetb, o_busy, o_ready, o_state
  );
endinterface

// File: rtl/cam_power_sequencer.sv
// OV5642 power-on sequencer: PWDN hold, RESETB hold, settle wait, then ready for SCCB.
// Pin outputs are registered decodes of the next state, so they change with the state register.
module cam_power_sequencer
  import cam_pkg::*;
#(
  parameter int unsigned T_PWDN_CYC = T_PWDN_DEF,
  parameter int unsigned T_RST_CYC  = T_RST_DEF,
  parameter int unsigned T_SCCB_CYC = T_SCCB_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  cam_power_sequencer_if.slave  cam
);

  localparam int unsigned CNT_W = $clog2(max3(T_PWDN_CYC, T_RST_CYC, T_SCCB_CYC)) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PWDN_LAST = cnt_t'(T_PWDN_CYC - 1);
  localparam cnt_t RST_LAST  = cnt_t'(T_RST_CYC - 1);
  localparam cnt_t SCCB_LAST = cnt_t'(T_SCCB_CYC - 1);

  cam_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cam_pins_t  pins_q, pins_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_PWDN;
      cnt_q   <= '0;
      pins_q  <= pins_of(S_PWDN);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pins_q  <= pins_d;
    end
  end

  // Power-down beats restart; restart beats normal sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cam.i_pwr_down) begin
      state_d = S_OFF;
      cnt_d   = '0;
    end else if (cam.i_restart) begin
      state_d = S_PWDN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_PWDN;
          cnt_d   = '0;
        end
        S_PWDN: begin
          if (cnt_q == PWDN_LAST) begin
            state_d = S_RST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        S_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == SCCB_LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
        S_READY: ;
        default: begin
          state_d = S_PWDN;
          cnt_d   = '0;
        end
      endcase
    end
    pins_d = pins_of(state_d);
  end

  assign cam.o_cam_pwdn   = pins_q.pwdn;
  assign cam.o_cam_resetb = pins_q.resetb;
  assign cam.o_busy       = pins_q.busy;
  assign cam.o_ready      = pins_q.ready;
  assign cam.o_state      = state_q;

endmodule

// File: tb/tb_cam_power_sequencer.sv
// Bench for cam_power_sequencer: directed scenarios then random restart/power-down/reset traffic,
// checked against an elapsed-edge reference model on a (4,3,5) instance and an all-ones instance.
module tb_cam_power_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic restart  = 1'b0;
  logic pwr_down = 1'b0;

  always #5 clk = ~clk;

  cam_power_sequencer_if ifa ();
  cam_power_sequencer_if ifb ();

  assign ifa.i_restart  = restart;
  assign ifa.i_pwr_down = pwr_down;
  assign ifb.i_restart  = restart;
  assign ifb.i_pwr_down = pwr_down;

  cam_power_sequencer #(.T_PWDN_CYC(4), .T_RST_CYC(3), .T_SCCB_CYC(5)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .cam(ifa)
  );
  cam_power_sequencer #(.T_PWDN_CYC(1), .T_RST_CYC(1), .T_SCCB_CYC(1)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .cam(ifb)
  );

  int checks   = 0;
  int failures = 0;

  // Model: either powered off, or k edges elapsed since the sequence (re)started.
  int k [2];
  bit off [2];

  function automatic int tp(int d); return d ? 1 : 4; endfunction
  function automatic int tr(int d); return d ? 1 : 3; endfunction
  function automatic int ts(int d); return d ? 1 : 5; endfunction
  function automatic int tot(int d); return tp(d) + tr(d) + ts(d); endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin k[d] = 0; off[d] = 1'b0; end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (pwr_down) begin
        off[d] = 1'b1; k[d] = 0;
      end else if (restart || off[d]) begin
        off[d] = 1'b0; k[d] = 0;
      end else if (k[d] < tot(d)) begin
        k[d]++;
      end
    end
  endtask

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [2:0] st, est;
    logic pw, rb, bs, rd;
    for (int d = 0; d < 2; d++) begin
      st = d ? ifb.o_state      : ifa.o_state;
      pw = d ? ifb.o_cam_pwdn   : ifa.o_cam_pwdn;
      rb = d ? ifb.o_cam_resetb : ifa.o_cam_resetb;
      bs = d ? ifb.o_busy       : ifa.o_busy;
      rd = d ? ifb.o_ready      : ifa.o_ready;
      if (off[d])                    est = 3'd0;
      else if (k[d] < tp(d))         est = 3'd1;
      else if (k[d] < tp(d) + tr(d)) est = 3'd2;
      else if (k[d] < tot(d))        est = 3'd3;
      else                           est = 3'd4;
      cmp($sformatf("%s.dut%0d.state",  tag, d), 32'(st), 32'(est));
      cmp($sformatf("%s.dut%0d.pwdn",   tag, d), 32'(pw), 32'(off[d] || k[d] < tp(d)));
      cmp($sformatf("%s.dut%0d.resetb", tag, d), 32'(rb), 32'(!off[d] && k[d] >= tp(d) + tr(d)));
      cmp($sformatf("%s.dut%0d.ready",  tag, d), 32'(rd), 32'(!off[d] && k[d] >= tot(d)));
      cmp($sformatf("%s.dut%0d.busy",   tag, d), 32'(bs), 32'(!off[d] && k[d] < tot(d)));
      cmp($sformatf("%s.dut%0d.invariant", tag, d), 32'(pw && rb), 32'd0);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    check_all(tag);
  endtask

  // Reset asserted mid-cycle, observed before any edge, then held across one edge.
  task automatic async_reset(string tag);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".noclk"});
    step({tag, ".held"});
    rst_n = 1'b1;
  endtask

  task automatic edges_to_ready(string tag, int exp_n);
    int n = 0;
    while (!ifa.o_ready && n < 40) begin step(tag); n++; end
    cmp({tag, ".latency"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pf0, rr0, rd0, pf1, rr1, rd1;
    model_reset();

    repeat (3) step("reset");
    cmp("reset.pwdn",   32'(ifa.o_cam_pwdn),   32'd1);
    cmp("reset.resetb", 32'(ifa.o_cam_resetb), 32'd0);
    cmp("reset.busy",   32'(ifa.o_busy),       32'd1);
    cmp("reset.ready",  32'(ifa.o_ready),      32'd0);
    rst_n = 1'b1;

    pf0 = -1; rr0 = -1; rd0 = -1; pf1 = -1; rr1 = -1; rd1 = -1;
    for (int e = 1; e <= 15; e++) begin
      step("powerup");
      if (pf0 < 0 && !ifa.o_cam_pwdn)  pf0 = e;
      if (rr0 < 0 &&  ifa.o_cam_resetb) rr0 = e;
      if (rd0 < 0 &&  ifa.o_ready)      rd0 = e;
      if (pf1 < 0 && !ifb.o_cam_pwdn)  pf1 = e;
      if (rr1 < 0 &&  ifb.o_cam_resetb) rr1 = e;
      if (rd1 < 0 &&  ifb.o_ready)      rd1 = e;
    end
    cmp("powerup.pwdn_fall_edge",   32'(pf0), 32'd4);
    cmp("powerup.resetb_rise_edge", 32'(rr0), 32'd7);
    cmp("powerup.ready_edge",       32'(rd0), 32'd12);
    cmp("t1.pwdn_fall_edge",        32'(pf1), 32'd1);
    cmp("t1.resetb_rise_edge",      32'(rr1), 32'd2);
    cmp("t1.ready_edge",            32'(rd1), 32'd3);

    restart = 1'b1; step("restart"); restart = 1'b0;
    cmp("restart.pwdn",  32'(ifa.o_cam_pwdn), 32'd1);
    cmp("restart.ready", 32'(ifa.o_ready),    32'd0);
    cmp("restart.busy",  32'(ifa.o_busy),     32'd1);
    edges_to_ready("restart", 12);

    restart = 1'b1; step("pd.restart"); restart = 1'b0;
    repeat (9) step("pd.run");
    cmp("pd.in_wait", 32'(ifa.o_state), 32'd3);
    pwr_down = 1'b1; step("pd.enter");
    cmp("pd.state_off", 32'(ifa.o_state),  32'd0);
    cmp("pd.busy",      32'(ifa.o_busy),   32'd0);
    cmp("pd.pwdn",      32'(ifa.o_cam_pwdn), 32'd1);
    restart = 1'b1; step("pd.restart_ignored"); restart = 1'b0;
    cmp("pd.restart_ignored", 32'(ifa.o_state), 32'd0);
    repeat (4) step("pd.hold");
    pwr_down = 1'b0;
    edges_to_ready("pd.release", 13);

    restart = 1'b1; step("both.restart"); restart = 1'b0;
    repeat (5) step("both.run");
    cmp("both.in_rst", 32'(ifa.o_state), 32'd2);
    restart = 1'b1; pwr_down = 1'b1; step("both.pulse");
    cmp("both.state_off", 32'(ifa.o_state), 32'd0);
    restart = 1'b0; pwr_down = 1'b0; step("both.after");
    cmp("both.state_pwdn", 32'(ifa.o_state), 32'd1);

    repeat (15) step("arst.run");
    cmp("arst.ready_before", 32'(ifa.o_ready), 32'd1);
    async_reset("arst");
    cmp("arst.ready_after", 32'(ifa.o_ready), 32'd0);
    edges_to_ready("arst.rerun", 12);

    for (int i = 0; i < 600; i++) begin
      restart = ($urandom_range(29) == 0);
      if ($urandom_range(19) == 0) pwr_down = ~pwr_down;
      if ($urandom_range(149) == 0) async_reset("rand.arst");
      step("rand");
    end
    restart = 1'b0;
    pwr_down = 1'b0;
    repeat (14) step("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
